// File: rtl/moving_avg_multi_ci.sv
// moving_avg_multi_ci
//   Multicycle custom instruction for a Nios II CPU: a multi-channel moving-average filter.
//   Each channel holds its last 2**LOG2_DEPTH samples plus a running sum. The sum is updated
//   in O(1) per sample: the new sample is added and the evicted sample is subtracted.
//
// Ports
//   clk     in   clock
//   reset   in   asynchronous, active-high reset
//   clk_en  in   clock enable; when low, the FSM and all registers hold
//   start   in   instruction start; honoured only in the idle state
//   dataa   in   sample in bits [DATA_W-1:0]
//   datab   in   [31:30] opcode (00 push, 01 read, 10 clear, 11 count), [7:0] channel
//   result  out  operation result; valid while done=1
//   done    out  one-cycle completion pulse; held while clk_en is low
//
// Configuration macro
//   MAVG_ROUND_EN  when defined, averages round half up instead of truncating (floor).
module moving_avg_multi_ci #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LOG2_DEPTH = 4,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SIGNED     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam int unsigned Depth = 2 ** LOG2_DEPTH;
    localparam int unsigned SumW  = DATA_W + LOG2_DEPTH;
    localparam int unsigned CntW  = LOG2_DEPTH + 1;
    localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam bit          IsSigned  = (SIGNED != 0);
    localparam logic [8:0]  ChanLimit = 9'(CHANNELS);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    typedef enum logic [1:0] {OpPush, OpRead, OpClear, OpCount} op_e;
    typedef enum logic [1:0] {StIdle, StFetch, StUpdate, StDone} state_e;

    state_e              state_q;
    op_e                 op_q;
    logic [7:0]          chan_q;
    logic [DATA_W-1:0]   sample_q;
    logic [DATA_W-1:0]   oldest_q;
    logic [31:0]         result_q;
    logic                done_q;

    logic [LOG2_DEPTH-1:0] ptr_q [CHANNELS];
    logic [SumW-1:0]       sum_q [CHANNELS];
    logic [CntW-1:0]       cnt_q [CHANNELS];
    // Sample store is deliberately not reset; the fill count masks stale entries.
    logic [DATA_W-1:0]     ram_q [CHANNELS][Depth];

    logic                  chan_ok;
    logic [ChanW-1:0]      chan_sel;
    logic [LOG2_DEPTH-1:0] cur_ptr;
    logic [SumW-1:0]       cur_sum;
    logic [CntW-1:0]       cur_cnt;
    logic [SumW-1:0]       sample_ext;
    logic [SumW-1:0]       evict_ext;
    logic [SumW-1:0]       push_sum;
    logic [31:0]           push_avg;
    logic [31:0]           read_avg;
    logic                  ram_we;

    logic unused_bits;
    assign unused_bits = ^{dataa[31:DATA_W], datab[29:8]};

    // Divide by the full window depth, then extend to the 32-bit result.
    function automatic logic [31:0] average(input logic [SumW-1:0] s);
        logic [SumW:0]     biased;
        logic [DATA_W-1:0] avg;
        biased = {IsSigned & s[SumW-1], s};
`ifdef MAVG_ROUND_EN
        biased = biased + (SumW + 1)'(Depth / 2);
`endif
        // The rounded quotient always fits in DATA_W bits, so the extra top bit can be dropped.
        avg = biased[SumW-1:LOG2_DEPTH];
        return IsSigned ? {{(32 - DATA_W){avg[DATA_W-1]}}, avg}
                        : {{(32 - DATA_W){1'b0}}, avg};
    endfunction

    always_comb begin
        chan_ok    = ({1'b0, chan_q} < ChanLimit);
        // Out-of-range channels alias channel 0 for reads only; every write is gated by chan_ok.
        chan_sel   = chan_ok ? chan_q[ChanW-1:0] : '0;
        cur_ptr    = ptr_q[chan_sel];
        cur_sum    = sum_q[chan_sel];
        cur_cnt    = cnt_q[chan_sel];
        sample_ext = {{LOG2_DEPTH{IsSigned & sample_q[DATA_W-1]}}, sample_q};
        evict_ext  = (cur_cnt == CntFull) ?
                     {{LOG2_DEPTH{IsSigned & oldest_q[DATA_W-1]}}, oldest_q} : '0;
        push_sum   = cur_sum + sample_ext - evict_ext;
        push_avg   = average(push_sum);
        read_avg   = average(cur_sum);
        ram_we     = clk_en && !reset && (state_q == StUpdate) && chan_ok && (op_q == OpPush);
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[chan_sel][cur_ptr] <= sample_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpPush;
            chan_q   <= '0;
            sample_q <= '0;
            oldest_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                ptr_q[i] <= '0;
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q     <= op_e'(datab[31:30]);
                        chan_q   <= datab[7:0];
                        sample_q <= dataa[DATA_W-1:0];
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    oldest_q <= ram_q[chan_sel][cur_ptr];
                    state_q  <= StUpdate;
                end
                StUpdate: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                    if (!chan_ok) begin
                        result_q <= '0;
                    end else begin
                        unique case (op_q)
                            OpPush: begin
                                sum_q[chan_sel] <= push_sum;
                                ptr_q[chan_sel] <= cur_ptr + LOG2_DEPTH'(1);
                                if (cur_cnt != CntFull) begin
                                    cnt_q[chan_sel] <= cur_cnt + CntW'(1);
                                end
                                result_q <= push_avg;
                            end
                            OpRead: begin
                                result_q <= read_avg;
                            end
                            OpClear: begin
                                ptr_q[chan_sel] <= '0;
                                sum_q[chan_sel] <= '0;
                                cnt_q[chan_sel] <= '0;
                                result_q        <= '0;
                            end
                            OpCount: begin
                                result_q <= 32'(cur_cnt);
                            end
                        endcase
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_moving_avg_multi_ci.sv
// Self-checking bench for moving_avg_multi_ci: one unsigned and one signed instance
// (default geometry: 16-bit samples, 16-deep window, 2 channels), checked against a
// history-based reference model.
module tb_moving_avg_multi_ci;

    localparam int Depth = 16;
    localparam int Chans = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        start_u;
    logic        start_s;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result_u;
    logic [31:0] result_s;
    logic        done_u;
    logic        done_s;

    int n_vec = 0;
    int n_err = 0;

    // Model: every sample ever pushed, per instance and channel; a window is the newest Depth.
    typedef struct {
        bit sgn;
        int ch;
        int val;
    } ent_t;
    ent_t hist[$];

    always #5 clk = ~clk;

    moving_avg_multi_ci #(
        .DATA_W(16), .LOG2_DEPTH(4), .CHANNELS(2), .SIGNED(0)
    ) dut_u (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_u),
        .dataa(dataa), .datab(datab), .result(result_u), .done(done_u)
    );

    moving_avg_multi_ci #(
        .DATA_W(16), .LOG2_DEPTH(4), .CHANNELS(2), .SIGNED(1)
    ) dut_s (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_s),
        .dataa(dataa), .datab(datab), .result(result_s), .done(done_s)
    );

    function automatic int div_depth(input int s);
        int t;
        t = s;
`ifdef MAVG_ROUND_EN
        t = t + Depth / 2;
`endif
        return (t >= 0) ? t / Depth : -((-t + Depth - 1) / Depth);
    endfunction

    task automatic model_op(input bit sgn, input logic [1:0] op, input logic [7:0] ch,
                            input logic [31:0] a, output logic [31:0] exp);
        int   n;
        int   s;
        ent_t e;
        ent_t keep[$];
        exp = '0;
        if (int'(ch) < Chans) begin
            if (op == 2'b00) begin
                e.sgn = sgn;
                e.ch  = int'(ch);
                e.val = sgn ? int'($signed(a[15:0])) : int'(a[15:0]);
                hist.push_back(e);
            end
            if (op == 2'b10) begin
                foreach (hist[i])
                    if (hist[i].sgn != sgn || hist[i].ch != int'(ch)) keep.push_back(hist[i]);
                hist = keep;
            end
            n = 0;
            s = 0;
            for (int i = hist.size() - 1; i >= 0 && n < Depth; i--) begin
                if (hist[i].sgn == sgn && hist[i].ch == int'(ch)) begin
                    n++;
                    s += hist[i].val;
                end
            end
            case (op)
                2'b00, 2'b01: exp = div_depth(s);
                2'b11:        exp = n;
                default:      exp = '0;
            endcase
        end
    endtask

    // Issue one instruction and wait (bounded) for done; lat is the cycle done appeared in.
    task automatic issue(input bit sgn, input logic [1:0] op, input logic [7:0] ch,
                         input logic [31:0] a, output logic [31:0] res, output int lat);
        @(negedge clk);
        dataa = a;
        datab = {op, 22'h0, ch};
        if (sgn) start_s = 1'b1;
        else     start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        start_s = 1'b0;
        dataa   = $urandom;
        datab   = $urandom;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if ((sgn ? done_s : done_u) === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
        res = sgn ? result_s : result_u;
        @(posedge clk); #1;
    endtask

    task automatic run_check(input string name, input bit sgn, input logic [1:0] op,
                             input logic [7:0] ch, input logic [31:0] a);
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        model_op(sgn, op, ch, a, exp);
        issue(sgn, op, ch, a, res, lat);
        n_vec++;
        if (res !== exp) begin
            n_err++;
            $display("FAIL %s result: got %h expected %h", name, res, exp);
        end
        n_vec++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL %s latency: got %0d expected 3", name, lat);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        clk_en  = 1'b1;
        start_u = 1'b0;
        start_s = 1'b0;
        dataa   = '0;
        datab   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (result_u !== 32'h0 || done_u !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got result=%h done=%b expected 0/0", result_u, done_u);
        end
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        run_check("reset_count_ch0", 1'b0, 2'b11, 8'd0, 32'h0);
        run_check("reset_read_ch1", 1'b0, 2'b01, 8'd1, 32'h0);
    endtask

    task automatic test_fill();
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        for (int i = 0; i < Depth; i++) run_check("fill_push100", 1'b0, 2'b00, 8'd0, 32'd100);
        n_vec++;
        if (result_u !== 32'h64) begin
            n_err++;
            $display("FAIL fill_final: got %h expected 00000064", result_u);
        end
        n_vec++;
        if (done_u !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse_width: got done=%b expected 0", done_u);
        end
        model_op(1'b0, 2'b11, 8'd0, 32'h0, exp);
        issue(1'b0, 2'b11, 8'd0, 32'h0, res, lat);
        n_vec++;
        if (res !== 32'd16 || exp !== 32'd16) begin
            n_err++;
            $display("FAIL fill_count: got %0d model %0d expected 16", res, exp);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < Depth; i++) run_check("wrap_push0", 1'b0, 2'b00, 8'd0, 32'd0);
        n_vec++;
        if (result_u !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_final: got %h expected 00000000", result_u);
        end
    endtask

    task automatic test_channels();
        run_check("ch1_push1600", 1'b0, 2'b00, 8'd1, 32'h640);
        run_check("ch0_read", 1'b0, 2'b01, 8'd0, 32'h0);
        run_check("bad_chan_push", 1'b0, 2'b00, 8'd5, 32'h7fff);
        run_check("bad_chan_count", 1'b0, 2'b11, 8'd255, 32'h0);
        run_check("ch1_count_after_bad", 1'b0, 2'b11, 8'd1, 32'h0);
        run_check("ch1_read_after_bad", 1'b0, 2'b01, 8'd1, 32'h0);
    endtask

    task automatic test_signed();
        for (int i = 0; i < Depth; i++) run_check("signed_push", 1'b1, 2'b00, 8'd0, 32'hffe0);
        n_vec++;
        if (result_s !== 32'hffffffe0) begin
            n_err++;
            $display("FAIL signed_full: got %h expected ffffffe0", result_s);
        end
        run_check("signed_clear", 1'b1, 2'b10, 8'd0, 32'h0);
        run_check("signed_push_m1", 1'b1, 2'b00, 8'd0, 32'hffff);
    endtask

    task automatic test_clear();
        run_check("clear_ch0", 1'b0, 2'b10, 8'd0, 32'h0);
        run_check("clear_count", 1'b0, 2'b11, 8'd0, 32'h0);
        for (int i = 0; i < 3; i++) run_check("clear_push16", 1'b0, 2'b00, 8'd0, 32'd16);
        run_check("clear_count3", 1'b0, 2'b11, 8'd0, 32'h0);
        run_check("clear_read", 1'b0, 2'b01, 8'd0, 32'h0);
        n_vec++;
        if (result_u !== 32'd3) begin
            n_err++;
            $display("FAIL clear_read_value: got %h expected 00000003", result_u);
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] exp;
        int          lat;
        model_op(1'b0, 2'b01, 8'd0, 32'h0, exp);
        @(negedge clk);
        datab   = {2'b01, 22'h0, 8'd0};
        start_u = 1'b1;
        @(posedge clk); #1;
        // A competing push to channel 1 is presented while the read is in flight.
        dataa = 32'h1234;
        datab = {2'b00, 22'h0, 8'd1};
        lat   = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start_u = 1'b0;
            if (done_u === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
        n_vec++;
        if (result_u !== exp || lat !== 3) begin
            n_err++;
            $display("FAIL busy_start: got %h lat %0d expected %h lat 3", result_u, lat, exp);
        end
        @(posedge clk); #1;
        run_check("busy_ch1_count", 1'b0, 2'b11, 8'd1, 32'h0);
    endtask

    task automatic test_clk_en();
        logic [31:0] exp;
        int          lat;
        model_op(1'b0, 2'b00, 8'd1, 32'd320, exp);
        @(negedge clk);
        dataa   = 32'd320;
        datab   = {2'b00, 22'h0, 8'd1};
        start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        clk_en  = 1'b0;
        lat     = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 5) clk_en = 1'b1;
            if (done_u === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
        n_vec++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL clk_en_latency: got %0d expected 8", lat);
        end
        n_vec++;
        if (result_u !== exp) begin
            n_err++;
            $display("FAIL clk_en_result: got %h expected %h", result_u, exp);
        end
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (done_u !== 1'b1 || result_u !== exp) begin
            n_err++;
            $display("FAIL clk_en_hold_done: got done=%b result=%h expected 1/%h",
                     done_u, result_u, exp);
        end
        clk_en = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (done_u !== 1'b0) begin
            n_err++;
            $display("FAIL clk_en_release: got done=%b expected 0", done_u);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dataa   = 32'hffff;
        datab   = {2'b00, 22'h0, 8'd0};
        start_u = 1'b1;
        @(posedge clk); #1;
        start_u = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_vec++;
        if (done_u !== 1'b0 || result_u !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: got done=%b result=%h expected 0/0", done_u, result_u);
        end
        hist.delete();
        @(negedge clk);
        reset = 1'b0;
        run_check("post_reset_push160", 1'b0, 2'b00, 8'd0, 32'd160);
        n_vec++;
        if (result_u !== 32'd10) begin
            n_err++;
            $display("FAIL post_reset_value: got %h expected 0000000a", result_u);
        end
        run_check("post_reset_count", 1'b0, 2'b11, 8'd0, 32'h0);
        run_check("post_reset_ch1_count", 1'b0, 2'b11, 8'd1, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [7:0]  ch;
        logic [31:0] a;
        bit          sgn;
        int          r;
        for (int i = 0; i < 120; i++) begin
            sgn = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 29);
            op  = (r < 21) ? 2'b00 : (r < 25) ? 2'b01 : (r < 28) ? 2'b11 : 2'b10;
            r   = $urandom_range(0, 9);
            ch  = (r < 9) ? 8'(r % 2) : 8'($urandom_range(2, 255));
            a   = $urandom;
            run_check("random_op", sgn, op, ch, a);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_channels();
        test_signed();
        test_clear();
        test_busy_start();
        test_clk_en();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
